// File: rtl/mem_arb_pkg.sv
// Shared types for the memory arbiter group: port count, port index and read-return tag.
package mem_arb_pkg;

  localparam int unsigned PORT_NUM = 4;

  typedef logic [1:0] port_idx_t;

  typedef struct packed {
    logic      valid;
    port_idx_t idx;
  } rd_tag_t;

endpackage

// File: rtl/m_rd_tag_pipe.sv
// Fixed-depth delay line carrying read-return tags alongside the RAM read latency.
module m_rd_tag_pipe
  import mem_arb_pkg::*;
#(
  parameter int unsigned DEPTH = 1
) (
  input  logic    clk,
  input  logic    rst_b,
  input  rd_tag_t tag_i,
  output rd_tag_t tag_o
);

  rd_tag_t [DEPTH-1:0] stage_q;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      stage_q <= '0;
    end else begin
      stage_q[0] <= tag_i;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign tag_o = stage_q[DEPTH-1];

endmodule

// File: rtl/rr_mem_arbiter.sv
// Four-port arbiter sharing one single-port RAM, with per-port read-valid return.
// Define RR_MEM_ARB_ROUND_ROBIN_EN for round-robin; otherwise fixed priority (port 0 highest).
module rr_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = 10,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst_b,
  input  logic                  mem_rd0_i,
  input  logic                  mem_wr0_i,
  input  logic [ADDR_WIDTH-1:0] mem_addr0_i,
  input  logic [DATA_WIDTH-1:0] mem_d4wr0_i,
  output logic                  mem_accept0_o,
  output logic                  mem_rvalid0_o,
  input  logic                  mem_rd1_i,
  input  logic                  mem_wr1_i,
  input  logic [ADDR_WIDTH-1:0] mem_addr1_i,
  input  logic [DATA_WIDTH-1:0] mem_d4wr1_i,
  output logic                  mem_accept1_o,
  output logic                  mem_rvalid1_o,
  input  logic                  mem_rd2_i,
  input  logic                  mem_wr2_i,
  input  logic [ADDR_WIDTH-1:0] mem_addr2_i,
  input  logic [DATA_WIDTH-1:0] mem_d4wr2_i,
  output logic                  mem_accept2_o,
  output logic                  mem_rvalid2_o,
  input  logic                  mem_rd3_i,
  input  logic                  mem_wr3_i,
  input  logic [ADDR_WIDTH-1:0] mem_addr3_i,
  input  logic [DATA_WIDTH-1:0] mem_d4wr3_i,
  output logic                  mem_accept3_o,
  output logic                  mem_rvalid3_o,
  output logic [DATA_WIDTH-1:0] mem_d4rd_o,
  output logic                  mem_rd_o,
  output logic                  mem_wr_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_d4wr_o,
  input  logic                  mem_accept_i,
  input  logic [DATA_WIDTH-1:0] mem_d4rd_i
);

  logic [PORT_NUM-1:0]   rd;
  logic [PORT_NUM-1:0]   req;
  logic [ADDR_WIDTH-1:0] addr  [PORT_NUM];
  logic [DATA_WIDTH-1:0] wdata [PORT_NUM];

  port_idx_t start;
  port_idx_t cand;
  port_idx_t gnt_idx;
  logic      gnt_valid;
  logic      xfer;
  rd_tag_t   tag_in;
  rd_tag_t   tag_out;

  assign rd  = {mem_rd3_i, mem_rd2_i, mem_rd1_i, mem_rd0_i};
  assign req = rd | {mem_wr3_i, mem_wr2_i, mem_wr1_i, mem_wr0_i};

  assign addr[0]  = mem_addr0_i;
  assign addr[1]  = mem_addr1_i;
  assign addr[2]  = mem_addr2_i;
  assign addr[3]  = mem_addr3_i;
  assign wdata[0] = mem_d4wr0_i;
  assign wdata[1] = mem_d4wr1_i;
  assign wdata[2] = mem_d4wr2_i;
  assign wdata[3] = mem_d4wr3_i;

  // First requester found scanning upward from start, wrapping 3 -> 0.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int unsigned k = 0; k < PORT_NUM; k++) begin
      cand = start + port_idx_t'(k);
      if (!gnt_valid && req[cand]) begin
        gnt_valid = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  assign xfer = gnt_valid & mem_accept_i;

`ifdef RR_MEM_ARB_ROUND_ROBIN_EN
  port_idx_t rr_q;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      rr_q <= '0;
    end else if (xfer) begin
      rr_q <= gnt_idx + 2'd1;
    end
  end

  assign start = rr_q;
`else
  assign start = '0;
`endif

  // A simultaneous rd+wr is a read; the write half is dropped.
  assign mem_rd_o   = gnt_valid & rd[gnt_idx];
  assign mem_wr_o   = gnt_valid & ~rd[gnt_idx];
  assign mem_addr_o = gnt_valid ? addr[gnt_idx] : '0;
  assign mem_d4wr_o = gnt_valid ? wdata[gnt_idx] : '0;

  assign mem_accept0_o = xfer && (gnt_idx == 2'd0);
  assign mem_accept1_o = xfer && (gnt_idx == 2'd1);
  assign mem_accept2_o = xfer && (gnt_idx == 2'd2);
  assign mem_accept3_o = xfer && (gnt_idx == 2'd3);

  assign tag_in.valid = xfer & rd[gnt_idx];
  assign tag_in.idx   = gnt_idx;

  m_rd_tag_pipe #(
    .DEPTH (READ_LATENCY)
  ) u_rd_tag_pipe (
    .clk   (clk),
    .rst_b (rst_b),
    .tag_i (tag_in),
    .tag_o (tag_out)
  );

  assign mem_rvalid0_o = tag_out.valid && (tag_out.idx == 2'd0);
  assign mem_rvalid1_o = tag_out.valid && (tag_out.idx == 2'd1);
  assign mem_rvalid2_o = tag_out.valid && (tag_out.idx == 2'd2);
  assign mem_rvalid3_o = tag_out.valid && (tag_out.idx == 2'd3);

  assign mem_d4rd_o = mem_d4rd_i;

endmodule

// File: tb/tb_rr_mem_arbiter.sv
// Scoreboard bench for rr_mem_arbiter with a two-cycle RAM model; expectations follow
// the build's policy (RR_MEM_ARB_ROUND_ROBIN_EN selects round-robin).
module tb_rr_mem_arbiter;

  localparam int LAT = 2;

  typedef struct {
    int          due;
    int          port;
    logic [31:0] data;
  } sb_entry_t;

  logic        clk = 1'b0;
  logic        rst_b;
  logic        rd    [4];
  logic        wr    [4];
  logic [9:0]  addr  [4];
  logic [31:0] wdata [4];
  logic        cont  [4];
  logic        accept_in;

  wire  [3:0]  acc_vec;
  wire  [3:0]  rv_vec;
  logic [31:0] mem_d4rd_o;
  logic        mem_rd_o;
  logic        mem_wr_o;
  logic [9:0]  mem_addr_o;
  logic [31:0] mem_d4wr_o;
  logic [31:0] mem_d4rd_i;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int m_ptr    = 0;

  sb_entry_t   sb [$];
  logic [31:0] exp_mem [int];
  logic [31:0] ram     [int];
  logic [31:0] rp0, rp1;

  always #5 clk = ~clk;

  rr_mem_arbiter #(
    .ADDR_WIDTH   (10),
    .DATA_WIDTH   (32),
    .READ_LATENCY (LAT)
  ) dut (
    .clk           (clk),
    .rst_b         (rst_b),
    .mem_rd0_i     (rd[0]),
    .mem_wr0_i     (wr[0]),
    .mem_addr0_i   (addr[0]),
    .mem_d4wr0_i   (wdata[0]),
    .mem_accept0_o (acc_vec[0]),
    .mem_rvalid0_o (rv_vec[0]),
    .mem_rd1_i     (rd[1]),
    .mem_wr1_i     (wr[1]),
    .mem_addr1_i   (addr[1]),
    .mem_d4wr1_i   (wdata[1]),
    .mem_accept1_o (acc_vec[1]),
    .mem_rvalid1_o (rv_vec[1]),
    .mem_rd2_i     (rd[2]),
    .mem_wr2_i     (wr[2]),
    .mem_addr2_i   (addr[2]),
    .mem_d4wr2_i   (wdata[2]),
    .mem_accept2_o (acc_vec[2]),
    .mem_rvalid2_o (rv_vec[2]),
    .mem_rd3_i     (rd[3]),
    .mem_wr3_i     (wr[3]),
    .mem_addr3_i   (addr[3]),
    .mem_d4wr3_i   (wdata[3]),
    .mem_accept3_o (acc_vec[3]),
    .mem_rvalid3_o (rv_vec[3]),
    .mem_d4rd_o    (mem_d4rd_o),
    .mem_rd_o      (mem_rd_o),
    .mem_wr_o      (mem_wr_o),
    .mem_addr_o    (mem_addr_o),
    .mem_d4wr_o    (mem_d4wr_o),
    .mem_accept_i  (accept_in),
    .mem_d4rd_i    (mem_d4rd_i)
  );

  function automatic logic [31:0] init_val(int a);
    return (32'(a) * 32'h0101_0101) ^ 32'hA5A5_0000;
  endfunction

  // RAM model driven by the DUT's RAM-side outputs.
  always @(posedge clk) begin
    if (mem_rd_o && accept_in) begin
      rp0 <= ram.exists(int'(mem_addr_o)) ? ram[int'(mem_addr_o)] : init_val(int'(mem_addr_o));
    end
    rp1 <= rp0;
    if (mem_wr_o && accept_in) ram[int'(mem_addr_o)] = mem_d4wr_o;
  end
  assign mem_d4rd_i = rp1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  function automatic logic [31:0] exp_read(int a);
    return exp_mem.exists(a) ? exp_mem[a] : init_val(a);
  endfunction

  task automatic clear_reqs();
    for (int p = 0; p < 4; p++) begin
      rd[p] = 1'b0; wr[p] = 1'b0; cont[p] = 1'b0;
    end
  endtask

  // One clock: compare at negedge, advance model state, then update requesters.
  task automatic cycle();
    logic      gv;
    int        g;
    logic [3:0] exp_acc;
    logic [3:0] exp_rv;
    sb_entry_t e;
    gv = 1'b0;
    g  = 0;
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      if (!gv && (rd[(m_ptr + k) % 4] || wr[(m_ptr + k) % 4])) begin
        gv = 1'b1;
        g  = (m_ptr + k) % 4;
      end
    end
    exp_acc = (gv && accept_in) ? (4'b0001 << g) : 4'b0000;
    check("accept", 32'(acc_vec), 32'(exp_acc));
    check("mem_rd", 32'(mem_rd_o), 32'(gv && rd[g]));
    check("mem_wr", 32'(mem_wr_o), 32'(gv && wr[g] && !rd[g]));
    check("mem_addr", 32'(mem_addr_o), gv ? 32'(addr[g]) : 32'h0);
    if (gv && wr[g] && !rd[g]) check("mem_d4wr", mem_d4wr_o, wdata[g]);
    exp_rv = 4'b0000;
    if (sb.size() > 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      exp_rv = 4'b0001 << e.port;
      check("rdata", mem_d4rd_o, e.data);
    end
    check("rvalid", 32'(rv_vec), 32'(exp_rv));
    if (gv && accept_in) begin
      if (rd[g]) sb.push_back('{due: cyc + LAT, port: g, data: exp_read(int'(addr[g]))});
      else exp_mem[int'(addr[g])] = wdata[g];
`ifdef RR_MEM_ARB_ROUND_ROBIN_EN
      m_ptr = (g + 1) % 4;
`endif
    end
    @(posedge clk);
    cyc++;
    #1;
    if (gv && accept_in) begin
      if (cont[g]) addr[g] = addr[g] + 10'd1;
      else begin
        rd[g] = 1'b0;
        wr[g] = 1'b0;
      end
    end
  endtask

  initial begin
    rst_b     = 1'b0;
    accept_in = 1'b1;
    clear_reqs();
    for (int p = 0; p < 4; p++) begin
      rd[p]    = 1'b1;
      addr[p]  = 10'(p * 3 + 1);
      wdata[p] = 32'h0;
    end
    #2;
    // Combinational path is live in reset with the pointer at port 0.
    check("reset_accept", 32'(acc_vec), 32'h1);
    check("reset_addr", 32'(mem_addr_o), 32'h1);
    check("reset_rvalid", 32'(rv_vec), 32'h0);
    clear_reqs();
    repeat (2) @(posedge clk);
    #1;
    rst_b = 1'b1;

    // All four ports reading continuously.
    for (int p = 0; p < 4; p++) begin
      rd[p] = 1'b1; cont[p] = 1'b1; addr[p] = 10'(10'h100 + p * 16);
    end
    repeat (8) cycle();
    clear_reqs();
    repeat (3) cycle();

    // RAM stalls for three cycles while ports 1 and 3 wait.
    rd[1] = 1'b1; addr[1] = 10'h011;
    rd[3] = 1'b1; addr[3] = 10'h033;
    accept_in = 1'b0;
    repeat (3) cycle();
    accept_in = 1'b1;
    repeat (5) cycle();

    // Single read from port 2.
    rd[2] = 1'b1; addr[2] = 10'h055;
    repeat (4) cycle();

    // Port 0 write then read-back at the top address.
    wr[0] = 1'b1; addr[0] = 10'h3FF; wdata[0] = 32'hDEAD_BEEF;
    cycle();
    rd[0] = 1'b1;
    repeat (4) cycle();

    // Port 1 rd+wr together is a read; follow-up read shows no write happened.
    rd[1] = 1'b1; wr[1] = 1'b1; addr[1] = 10'h222; wdata[1] = 32'h1234_5678;
    cycle();
    rd[1] = 1'b1;
    repeat (4) cycle();

    // Reset while two reads are in flight.
    rd[1] = 1'b1; addr[1] = 10'h0A1;
    rd[2] = 1'b1; addr[2] = 10'h0A2;
    repeat (2) cycle();
    clear_reqs();
    rst_b = 1'b0;
    #3;
    check("midreset_rvalid", 32'(rv_vec), 32'h0);
    @(posedge clk);
    #1;
    rst_b = 1'b1;
    cyc++;
    sb.delete();
    m_ptr = 0;
    repeat (3) cycle();
    for (int p = 0; p < 4; p++) rd[p] = 1'b1;
    cycle();
    clear_reqs();
    repeat (4) cycle();

    check("sb_drained", 32'(sb.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/rr_mem_arbiter.md
# rr_mem_arbiter

Four-port arbiter that shares one single-port RAM (read and write) between baseband requesters such as the correlator, the AE buffer and the host interface. It supports a round-robin policy with a rotating priority pointer. It tracks each accepted read through the memory's fixed read latency and returns a per-port read-valid strobe with the shared read data. It sits between the requesting blocks and the RAM wrapper, in the same mem_arbiter group as the combinational ROM arbiter.

## Interface
Parameters:
- ADDR_WIDTH, 10, address width
- DATA_WIDTH, 32, data width
- READ_LATENCY, 1, RAM read latency in cycles, legal range 1..4

Ports (n = 0..3, one set per port):
- clk  in  1  system clock
- rst_b  in  1  reset; one clock; reset is asynchronous and active-low
- mem_rdn_i  in  1  port n read request
- mem_wrn_i  in  1  port n write request
- mem_addrn_i  in  ADDR_WIDTH  port n address
- mem_d4wrn_i  in  DATA_WIDTH  port n write data
- mem_acceptn_o  out  1  port n request accepted this cycle
- mem_rvalidn_o  out  1  port n read data valid on mem_d4rd_o
- mem_d4rd_o  out  DATA_WIDTH  shared read data, pass-through of mem_d4rd_i
- mem_rd_o / mem_wr_o  out  1  RAM read / write strobe
- mem_addr_o  out  ADDR_WIDTH  RAM address
- mem_d4wr_o  out  DATA_WIDTH  RAM write data
- mem_accept_i  in  1  RAM can take a request this cycle
- mem_d4rd_i  in  DATA_WIDTH  RAM read data

## Operation
- Request from port n: req[n] = mem_rdn_i | mem_wrn_i. If both rd and wr are asserted, the request is a read and the write is ignored.
- Grant selection is combinational in the same cycle. It is the first requesting port starting from rr_ptr, searching upward with wrap 3→0.
- mem_rd_o and mem_wr_o reflect the selected port's request type, and are 0 when no port is requesting.
- mem_addr_o and mem_d4wr_o mux in the selected port's inputs. Both are 0 when there is no request.
- Accept: mem_acceptn_o = 1 only for the selected port, and only when mem_accept_i = 1. At most one accept is high per cycle.
- Requesters hold their request stable until accepted.
- rr_ptr (2 bits, registered) is updated only on an accepted transfer, to granted index + 1 mod 4. It holds otherwise, including when mem_accept_i = 0.
- Read return:
  - Each accepted read pushes {valid=1, port index} into a READ_LATENCY-deep tag shift register. Non-read cycles push valid=0.
  - The tag at the output raises mem_rvalid<idx>_o for exactly one cycle.
  - A read accepted at cycle t produces rvalid at cycle t+READ_LATENCY.
- Back-to-back reads to any mix of ports are allowed every cycle. Returned data stays in request order.

## Timing
- Reset values:
  - rr_ptr = 0.
  - All tag stages have valid = 0.
  - All mem_rvalidn_o = 0.
  - Combinational outputs follow the inputs, evaluated with rr_ptr = 0.
- Reset asserted mid-operation: in-flight reads are discarded, and their rvalid is never produced.
- Grant-to-accept latency is 0 cycles. Read data latency is READ_LATENCY cycles.
- mem_accept_i = 0: no accept outputs, no tag push, rr_ptr holds. mem_rd_o and mem_wr_o may still be high, with the RAM ignoring them.
- Single requester: it is granted every cycle, whatever the value of rr_ptr.

## Configuration
- RR_MEM_ARB_ROUND_ROBIN_EN defined: round-robin policy as described above.
- Not defined:
  - Fixed priority, port 0 highest, then 1, 2, 3.
  - rr_ptr is not implemented and the search always starts at 0.
  - Read-return tracking is unchanged.

## Structure
- Package mem_arb_pkg holds:
  - PORT_NUM = 4.
  - Typedef port_idx_t (2 bits).
  - Typedef rd_tag_t {valid, port_idx_t}.
- Sub-module m_rd_tag_pipe is the parameterised READ_LATENCY delay line of rd_tag_t, with async reset.

## Test plan
- Single read, port 2 at addr 0x055, READ_LATENCY = 2 → mem_accept2_o same cycle, mem_rvalid2_o exactly 2 cycles later with the RAM model data.
- All 4 ports reading continuously with the macro defined → accepts rotate 0,1,2,3,0 in successive cycles, and each rvalid is matched to its port in order.
- Same stimulus without the macro → port 0 accepted every cycle, and ports 1–3 are never accepted.
- mem_accept_i held 0 for 3 cycles while ports 1 and 3 request → no accepts, rr_ptr unchanged. After release, port 1 is accepted, then port 3.
- Port 0 write (addr 0x3FF, data 0xDEADBEEF) followed by port 0 read of 0x3FF → mem_wr_o with the correct data, then rvalid0 returns 0xDEADBEEF. Port 1 asserting rd and wr together → treated as a read.
- rst_b pulsed low while 2 reads are in flight → no rvalid for them, and rr_ptr = 0 after reset.
